axis_tgen_chk: RTL and testbench
================================

# axis_tgen_chk

Parametrised AXI-Stream frame generator and checker pair for FIFO/interconnect bring-up. The generator drives numbered, multi-channel frames (TDEST round-robin, partial last beat) on a master port. The checker consumes the looped-back stream on a slave port, applies a programmable backpressure pattern, and counts frames and errors. It replaces fixed-size single-channel example traffic in simulation and on-chip self-test tops.

## Interface
- DATA_W, 32, tdata width (multiple of 8)
- KEEP_W, DATA_W/8, tkeep width
- USER_W, 1, tuser width; bit 0 = start-of-frame
- DEST_W, 2, tdest width
- NUM_CH, 4, channels rotated on tdest; 1..2**DEST_W
- FRAME_BEATS, 8, beats per frame; >=1
- LAST_BYTES, KEEP_W, valid bytes in final beat; 1..KEEP_W
- CNT_W, 16, status counter width
---
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- enable  in  1  generator run request
- num_frames  in  CNT_W  frames to send; 0 = unlimited
- stall_mode  in  2  checker tready pattern: 0 always, 1 alternate, 2 LFSR, 3 never
- m_axis_tdata/tkeep/tuser/tdest/tlast/tvalid  out  DATA_W/KEEP_W/USER_W/DEST_W/1/1  generator stream
- m_axis_tready  in  1
- s_axis_tdata/tkeep/tuser/tdest/tlast/tvalid  in  (same widths)  checker stream
- s_axis_tready  out  1
- frames_sent, frames_rcvd, err_count  out  CNT_W  saturating counters
- err_flag  out  1  sticky, set on first error
- done  out  1  generator finished and all sent frames received

## Operation
- Reset: all outputs 0; FSM IDLE; word/frame counters 0; LFSR = 16'hACE1.
- Generator FSM IDLE -> SEND when enable=1. SEND -> DONE after the last beat of frame num_frames is accepted (num_frames!=0). SEND -> IDLE at a frame boundary when enable=0. enable is never sampled mid-frame. DONE -> IDLE when enable=0.
- Beat content: tdata = global word counter (DATA_W bits, wraps, never reset except by areset); tdest = frame index mod NUM_CH; tuser[0]=1 on beat 0 only, other tuser bits 0; tlast on beat FRAME_BEATS-1; tkeep all ones except the last beat = LAST_BYTES low bits set.
- AXIS rule: when tvalid=1 and tready=0, all m_axis signals are held stable.
- Checker keeps its own expected word/beat/frame counters, advanced per s_axis handshake. One error per beat on any mismatch in: tdata (bytes enabled by expected tkeep only), tkeep, tuser[0], tdest, tlast.
- Resync: on a received tlast, the beat index resets to 0 and the frame index advances, whether or not tlast was expected. A missing tlast is counted once, at the beat where it was due.
- frames_rcvd increments on each received tlast. All counters saturate at 2**CNT_W-1.
- s_axis_tready by mode: 0 = 1; 1 = toggles every cycle, starting at 1; 2 = LFSR bit 0 (x^16+x^14+x^13+x^11+1, shifts every cycle); 3 = 0.
- done = (FSM==DONE) && frames_rcvd==frames_sent.

## Timing
- m_axis_tvalid is registered: it rises 1 cycle after enable is sampled high in IDLE.
- With tready held high: 1 beat/cycle, no bubble between frames.
- Counters, err_flag and done update 1 cycle after the causing handshake.
- s_axis_tready is registered from mode/LFSR. A stall_mode change takes effect the next cycle.
- areset mid-frame: outputs clear asynchronously. The next run restarts from word 0, frame 0.

## Structure
- Package axis_tgen_pkg: FSM state enum (IDLE, SEND, DONE), stall-mode constants, LFSR seed/taps, function last_keep(LAST_BYTES, KEEP_W).
- Sub-module axis_stream_checker: checker, counters and tready pattern. The top holds the generator FSM and done logic.

## Test plan
- Loopback m->s, stall_mode 0, num_frames=3, FRAME_BEATS=8 -> tdata 0..23 in 24 consecutive cycles; frames_sent=frames_rcvd=3; err_count 0; done=1.
- m_axis_tready low for 5 cycles at beat 3 -> tdata/tkeep/tlast held at 3 throughout; no error.
- Flip tdata bit 0 on word 10 in the loop -> err_count=1, err_flag=1; later beats clean.
- Suppress tlast on frame 0 -> exactly 1 error at beat 7; frame 1 is checked against frame 1 content after the next tlast resync.
- LAST_BYTES=2, NUM_CH=4, 5 frames -> last-beat tkeep=4'b0011; tdest sequence 0,1,2,3,0.
- areset asserted at beat 4 with stall_mode 2 -> all outputs 0 immediately; rerun gives tdata restarting at 0 and err_count 0.

Source files
------------

// File: rtl/axis_tgen_pkg.sv
// Shared types and constants for the AXI-Stream frame generator/checker pair.
// Covers the generator FSM states, tready pattern modes, LFSR setup and the last-beat keep mask.
package axis_tgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } gen_state_t;

    localparam logic [1:0] STALL_NONE = 2'd0;
    localparam logic [1:0] STALL_ALT  = 2'd1;
    localparam logic [1:0] STALL_LFSR = 2'd2;
    localparam logic [1:0] STALL_ALL  = 2'd3;

    // Fibonacci x^16+x^14+x^13+x^11+1, shifting right: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int MAX_KEEP_W = 256;

    function automatic logic [MAX_KEEP_W-1:0] last_keep(input int last_bytes, input int keep_w);
        logic [MAX_KEEP_W-1:0] k;
        k = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            if (i < last_bytes && i < keep_w) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_stream_checker.sv
// Slave-side stream checker: tracks expected word/beat/channel, counts frames and errors,
// and drives a registered tready pattern selected by stall_mode.
module axis_stream_checker
    import axis_tgen_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int KEEP_W      = DATA_W/8,
    parameter int USER_W      = 1,
    parameter int DEST_W      = 2,
    parameter int NUM_CH      = 4,
    parameter int FRAME_BEATS = 8,
    parameter int LAST_BYTES  = KEEP_W,
    parameter int CNT_W       = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [1:0]        stall_mode,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic [USER_W-1:0] s_axis_tuser,
    input  logic [DEST_W-1:0] s_axis_tdest,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [CNT_W-1:0]  frames_rcvd,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_flag
);

    localparam int BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [KEEP_W-1:0] LAST_KEEP = KEEP_W'(last_keep(LAST_BYTES, KEEP_W));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS-1);
    localparam logic [DEST_W-1:0] LAST_CH   = DEST_W'(NUM_CH-1);

    logic [DATA_W-1:0] exp_word;
    logic [BEAT_W-1:0] exp_beat;
    logic [DEST_W-1:0] exp_dest;
    logic [15:0]       lfsr;
    logic              alt_phase;
    logic              tready_q;

    logic              hs;
    logic              exp_last;
    logic [KEEP_W-1:0] exp_keep;
    logic [DATA_W-1:0] byte_mask;
    logic              beat_err;

    assign s_axis_tready = tready_q;
    assign hs            = s_axis_tvalid && tready_q;

    always_comb begin
        exp_last  = (exp_beat == LAST_BEAT);
        exp_keep  = exp_last ? LAST_KEEP : '1;
        byte_mask = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            byte_mask[b*8 +: 8] = {8{exp_keep[b]}};
        end
        beat_err = (((s_axis_tdata ^ exp_word) & byte_mask) != '0)
                || (s_axis_tkeep != exp_keep)
                || (s_axis_tuser[0] != (exp_beat == '0))
                || (s_axis_tdest != exp_dest)
                || (s_axis_tlast != exp_last);
    end

    // A received tlast or a due-but-missing tlast both close the expected frame,
    // so a single dropped tlast costs exactly one error.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            exp_word    <= '0;
            exp_beat    <= '0;
            exp_dest    <= '0;
            frames_rcvd <= '0;
            err_count   <= '0;
            err_flag    <= 1'b0;
        end else if (hs) begin
            exp_word <= exp_word + 1'b1;
            if (s_axis_tlast || exp_last) begin
                exp_beat <= '0;
                exp_dest <= (exp_dest == LAST_CH) ? '0 : exp_dest + 1'b1;
            end else begin
                exp_beat <= exp_beat + 1'b1;
            end
            if (s_axis_tlast && frames_rcvd != '1) frames_rcvd <= frames_rcvd + 1'b1;
            if (beat_err) begin
                err_flag <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            lfsr      <= LFSR_SEED;
            alt_phase <= 1'b0;
            tready_q  <= 1'b0;
        end else begin
            lfsr      <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
            alt_phase <= (stall_mode == STALL_ALT) ? ~alt_phase : 1'b0;
            case (stall_mode)
                STALL_NONE: tready_q <= 1'b1;
                STALL_ALT:  tready_q <= ~alt_phase;
                STALL_LFSR: tready_q <= lfsr[0];
                default:    tready_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/axis_tgen_chk.sv
// AXI-Stream frame generator with looped-back checker for interconnect/FIFO bring-up.
//   state | meaning
//   IDLE  | no traffic; waits for enable
//   SEND  | streaming frames; enable only sampled at frame boundaries
//   DONE  | num_frames sent; waits for enable to drop
module axis_tgen_chk
    import axis_tgen_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int KEEP_W      = DATA_W/8,
    parameter int USER_W      = 1,
    parameter int DEST_W      = 2,
    parameter int NUM_CH      = 4,
    parameter int FRAME_BEATS = 8,
    parameter int LAST_BYTES  = KEEP_W,
    parameter int CNT_W       = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  num_frames,
    input  logic [1:0]        stall_mode,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic [DEST_W-1:0] m_axis_tdest,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic [USER_W-1:0] s_axis_tuser,
    input  logic [DEST_W-1:0] s_axis_tdest,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [CNT_W-1:0]  frames_sent,
    output logic [CNT_W-1:0]  frames_rcvd,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_flag,
    output logic              done
);

    localparam int BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [KEEP_W-1:0] LAST_KEEP = KEEP_W'(last_keep(LAST_BYTES, KEEP_W));
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS-1);
    localparam logic [DEST_W-1:0] LAST_CH   = DEST_W'(NUM_CH-1);

    gen_state_t        state, state_nxt;
    logic [DATA_W-1:0] word_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [DEST_W-1:0] dest_cnt;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  frames_sent_q;

    logic m_hs;
    logic gen_last;
    logic end_of_run;

    assign m_hs       = m_axis_tvalid && m_axis_tready;
    assign gen_last   = (beat_cnt == LAST_BEAT);
    assign end_of_run = (num_frames != '0) && (run_cnt == num_frames - 1'b1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = SEND;
            SEND: begin
                if (m_hs && gen_last) begin
                    if (end_of_run)   state_nxt = DONE;
                    else if (!enable) state_nxt = IDLE;
                end
            end
            DONE: if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word and channel counters are global across runs; only areset restarts them,
    // keeping the checker's expectations aligned after IDLE/DONE pauses.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            word_cnt      <= '0;
            beat_cnt      <= '0;
            dest_cnt      <= '0;
            run_cnt       <= '0;
            frames_sent_q <= '0;
        end else begin
            state <= state_nxt;
            if (m_hs) begin
                word_cnt <= word_cnt + 1'b1;
                if (gen_last) begin
                    beat_cnt <= '0;
                    dest_cnt <= (dest_cnt == LAST_CH) ? '0 : dest_cnt + 1'b1;
                    run_cnt  <= run_cnt + 1'b1;
                    if (frames_sent_q != '1) frames_sent_q <= frames_sent_q + 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            if (state == IDLE) run_cnt <= '0;
        end
    end

    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tdata  = word_cnt;
    assign m_axis_tkeep  = !m_axis_tvalid ? '0 : (gen_last ? LAST_KEEP : '1);
    assign m_axis_tuser  = USER_W'(m_axis_tvalid && (beat_cnt == '0));
    assign m_axis_tdest  = m_axis_tvalid ? dest_cnt : '0;
    assign m_axis_tlast  = m_axis_tvalid && gen_last;
    assign frames_sent   = frames_sent_q;
    assign done          = (state == DONE) && (frames_rcvd == frames_sent_q);

    axis_stream_checker #(
        .DATA_W      (DATA_W),
        .KEEP_W      (KEEP_W),
        .USER_W      (USER_W),
        .DEST_W      (DEST_W),
        .NUM_CH      (NUM_CH),
        .FRAME_BEATS (FRAME_BEATS),
        .LAST_BYTES  (LAST_BYTES),
        .CNT_W       (CNT_W)
    ) u_checker (
        .aclk          (aclk),
        .areset        (areset),
        .stall_mode    (stall_mode),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .frames_rcvd   (frames_rcvd),
        .err_count     (err_count),
        .err_flag      (err_flag)
    );

endmodule

// File: tb/tb_axis_tgen_chk.sv
// Loopback bench for axis_tgen_chk: directed runs with a beat scoreboard on the master port
// plus status checks, including tdata/tlast fault injection and mid-frame reset.
module tb_axis_tgen_chk;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] num_frames = '0;
    logic [1:0]  stall_mode = 2'd0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic [0:0]  m_tuser;
    logic [1:0]  m_tdest;
    logic        m_tlast, m_tvalid, m_tready;
    logic [31:0] s_tdata;
    logic        s_tlast, s_tvalid, s_tready;
    logic [15:0] frames_sent, frames_rcvd, err_count;
    logic        err_flag, done;

    logic hold = 1'b0, flip_en = 1'b0, kill_en = 1'b0;

    assign m_tready = s_tready && !hold;
    assign s_tvalid = m_tvalid && !hold;
    assign s_tdata  = m_tdata ^ ((flip_en && m_tdata == 32'd10) ? 32'd1 : 32'd0);
    assign s_tlast  = m_tlast && !(kill_en && m_tdata == 32'd7);

    axis_tgen_chk #(.LAST_BYTES(2)) dut (
        .aclk(aclk), .areset(areset), .enable(enable), .num_frames(num_frames),
        .stall_mode(stall_mode),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tdest(m_tdest), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(m_tkeep), .s_axis_tuser(m_tuser),
        .s_axis_tdest(m_tdest), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .frames_sent(frames_sent), .frames_rcvd(frames_rcvd), .err_count(err_count),
        .err_flag(err_flag), .done(done)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        user;
        logic [1:0]  dest;
        logic        last;
    } beat_t;

    beat_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frames are 8 beats, LAST_BYTES=2 -> last keep 4'b0011, tdest rotates over 4 channels.
    task automatic push_words(input int nwords);
        beat_t b;
        for (int w = 0; w < nwords; w++) begin
            b.data = 32'(w);
            b.last = (w % 8 == 7);
            b.keep = b.last ? 4'b0011 : 4'b1111;
            b.user = (w % 8 == 0);
            b.dest = 2'((w / 8) % 4);
            q.push_back(b);
        end
    endtask

    initial begin : monitor
        beat_t exp_b, act_b;
        forever begin
            @(negedge aclk);
            #2;
            if (m_tvalid && m_tready) begin
                act_b = {m_tdata, m_tkeep, m_tuser[0], m_tdest, m_tlast};
                if (q.size() == 0) begin
                    check("unexpected_beat", 64'(act_b), 64'hDEAD);
                end else begin
                    exp_b = q.pop_front();
                    check("beat", 64'(act_b), 64'(exp_b));
                end
            end
        end
    end

    task automatic do_reset(input logic [1:0] mode);
        areset = 1'b1;
        enable = 1'b0;
        hold = 1'b0; flip_en = 1'b0; kill_en = 1'b0;
        stall_mode = mode;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        repeat (2) @(negedge aclk);
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget && !done; i++) @(negedge aclk);
        check(name, 64'(done), 64'd1);
    endtask

    task automatic finish_run(input string name);
        enable = 1'b0;
        repeat (3) @(negedge aclk);
        check(name, 64'(q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int good;
        int i;
        // reset state
        @(negedge aclk);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata", 64'(m_tdata), 64'd0);
        check("rst_tkeep", 64'(m_tkeep), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_tuser", 64'(m_tuser), 64'd0);
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_counts", 64'({frames_sent, frames_rcvd, err_count}), 64'd0);
        check("rst_flags", 64'({err_flag, done}), 64'd0);
        do_reset(2'd0);

        // A: 3 frames back to back, tdata 0..23 on consecutive cycles
        num_frames = 16'd3;
        push_words(24);
        enable = 1'b1;
        for (i = 0; i < 20 && !m_tvalid; i++) @(negedge aclk);
        good = 0;
        for (int k = 0; k < 24; k++) begin
            if (m_tvalid && m_tready && m_tdata == 32'(k)) good++;
            @(negedge aclk);
        end
        check("A_consecutive", 64'(good), 64'd24);
        wait_done("A_done", 50);
        check("A_sent", 64'(frames_sent), 64'd3);
        check("A_rcvd", 64'(frames_rcvd), 64'd3);
        check("A_err", 64'(err_count), 64'd0);
        finish_run("A_queue_empty");
        check("A_done_drop", 64'(done), 64'd0);

        // B: stall 5 cycles at beat 3
        do_reset(2'd0);
        num_frames = 16'd1;
        push_words(8);
        enable = 1'b1;
        for (i = 0; i < 50 && !(m_tvalid && m_tdata == 32'd3); i++) @(negedge aclk);
        hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("B_hold", 64'({m_tvalid, m_tdata, m_tkeep, m_tlast}),
                  64'({1'b1, 32'd3, 4'b1111, 1'b0}));
            @(negedge aclk);
        end
        hold = 1'b0;
        wait_done("B_done", 50);
        check("B_err", 64'(err_count), 64'd0);
        finish_run("B_queue_empty");

        // C: bit 0 of word 10 flipped in the loop
        do_reset(2'd0);
        num_frames = 16'd3;
        flip_en = 1'b1;
        push_words(24);
        enable = 1'b1;
        wait_done("C_done", 80);
        check("C_err", 64'(err_count), 64'd1);
        check("C_flag", 64'(err_flag), 64'd1);
        finish_run("C_queue_empty");

        // D: tlast of frame 0 suppressed
        do_reset(2'd0);
        num_frames = 16'd3;
        kill_en = 1'b1;
        push_words(24);
        enable = 1'b1;
        for (i = 0; i < 80 && frames_sent != 16'd3; i++) @(negedge aclk);
        repeat (3) @(negedge aclk);
        check("D_sent", 64'(frames_sent), 64'd3);
        check("D_err", 64'(err_count), 64'd1);
        check("D_rcvd", 64'(frames_rcvd), 64'd2);
        check("D_done", 64'(done), 64'd0);
        finish_run("D_queue_empty");

        // E: 5 frames, alternate backpressure; tdest 0,1,2,3,0 and keep 0011 via scoreboard
        do_reset(2'd1);
        num_frames = 16'd5;
        push_words(40);
        enable = 1'b1;
        wait_done("E_done", 400);
        check("E_rcvd", 64'(frames_rcvd), 64'd5);
        check("E_err", 64'(err_count), 64'd0);
        finish_run("E_queue_empty");

        // F: areset at beat 4 under LFSR backpressure, then rerun from word 0
        do_reset(2'd2);
        num_frames = 16'd0;
        push_words(4);
        enable = 1'b1;
        for (i = 0; i < 400 && !(m_tvalid && m_tdata == 32'd4); i++) @(negedge aclk);
        check("F_reached_beat4", 64'(m_tdata), 64'd4);
        areset = 1'b1;
        #1;
        check("F_rst_stream", 64'({m_tvalid, m_tdata, m_tkeep, m_tuser, m_tdest, m_tlast}), 64'd0);
        check("F_rst_status", 64'({s_tready, frames_sent, frames_rcvd, err_count, err_flag, done}), 64'd0);
        enable = 1'b0;
        check("F_queue_empty", 64'(q.size()), 64'd0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        repeat (2) @(negedge aclk);
        num_frames = 16'd2;
        push_words(16);
        enable = 1'b1;
        wait_done("F_done", 400);
        check("F_err", 64'(err_count), 64'd0);
        check("F_sent", 64'(frames_sent), 64'd2);
        finish_run("F_rerun_queue_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
